multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock for the state register.
REQ-002 rst  input  1  reset: asynchronous, active-high; forces state FETCH.
REQ-003 opcode  input  6  instruction[31:26]; stable after FETCH completes, because IR is written only in FETCH.
REQ-004 funct  input  6  instruction[5:0].
REQ-005 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; the current access completes in the cycle this is 1.
REQ-007 pc_write  output  1  PC load enable.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemRead, MemWrite, IRWrite, RegWrite  output  1 each  read / write / IR / register-file enables.
REQ-010 RegDst, MemToReg, ALUSrcA  output  1 each  datapath muxes: rd vs rt, MDR vs ALUOut, A vs PC.
REQ-011 ALUSrcB  output  2  operand B: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-012 ALUOp  output  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded, 11 = opcode-decoded immediate op.
REQ-013 PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 state  output  4  current state (debug).
REQ-015 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-016 illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-017 States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11; codes 12-15 go to FETCH next cycle, with all enables 0.
REQ-018 Outputs are decoded from state (Moore), except pc_write in BRANCH and every enable gated by mem_ready.
REQ-019 All outputs not listed for a state are 0.
REQ-020 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=pc_write=mem_ready; hold in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-021 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode:
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x00 -> R_EXEC
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 or 0x0D -> I_EXEC
  - anything else -> FETCH, with illegal_op=1.
REQ-022 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEM_READ if opcode=0x23, else MEM_WRITE.
REQ-023 MEM_READ: MemRead=1, IorD=1; hold until mem_ready, then MEM_WB.
REQ-024 MEM_WB: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1; then FETCH.
REQ-025 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready; instr_done=mem_ready; then FETCH.
REQ-026 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then R_WB.
REQ-027 R_WB: RegDst=1, MemToReg=0, RegWrite=1 unless funct=0x08 (JR), instr_done=1; then FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, pc_write=zero (beq), instr_done=1; then FETCH.
REQ-029 JUMP: PCSource=10, pc_write=1, instr_done=1; then FETCH.
REQ-030 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11; then I_WB.
REQ-031 I_WB: RegWrite=1, RegDst=0, MemToReg=0, instr_done=1; then FETCH.
REQ-032 Latency with mem_ready held 1:
  - beq/j: 3 cycles
  - R-type/addi/ori/sw: 4 cycles
  - lw: 5 cycles
  - each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle.

Reset
REQ-033 While rst=1: state=FETCH and every output=0, including MemRead; rst asserted mid-instruction aborts it, with no partial write enables asserted.
REQ-034 First rising clk after rst deasserts evaluates FETCH normally.

Configuration
REQ-035 Macro MULTICYCLE_BNE_EN.
  - Defined: opcode 0x05 -> BRANCH, with pc_write=~zero.
  - Undefined: opcode 0x05 is illegal (illegal_op pulse, return to FETCH).

Structure
REQ-036 Package mips_ctrl_pkg holds the state enum, opcode/funct constants, and ALUOp/ALUSrcB/PCSource encodings.
REQ-037 One sub-module, mc_out_decode: combinational state/opcode/zero/mem_ready -> control outputs; the top holds only the state register and next-state logic.

Verification
REQ-038 add (opcode 0x00, funct 0x20), mem_ready=1: states 0,1,6,7; RegWrite=1 and RegDst=1 in cycle 4; instr_done in cycle 4.
REQ-039 lw (0x23), mem_ready low for 2 cycles in MEM_READ: MEM_READ held 3 cycles; RegWrite=1 and MemToReg=1 in MEM_WB; total 7 cycles.
REQ-040 beq (0x04): with zero=1, pc_write=1 and PCSource=01 in BRANCH; with zero=0, pc_write=0.
REQ-041 jr (opcode 0x00, funct 0x08): RegWrite=0 in R_WB.
REQ-042 Opcode 0x3F: illegal_op pulse in DECODE, then FETCH.
REQ-043 With MULTICYCLE_BNE_EN defined, 0x05 with zero=0 gives pc_write=1; undefined, 0x05 gives illegal_op.
REQ-044 rst asserted in MEM_WRITE: MemWrite drops to 0 immediately, state=0; normal FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Build option: MULTICYCLE_BNE_EN adds bne (opcode 0x05) as a branch.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIExec    = 4'd10,
    StIWb      = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FunctJr = 6'h08;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // DECODE successor; StFetch doubles as the "unsupported opcode" marker.
  function automatic state_e decode_next(input logic [5:0] opcode);
    state_e nxt;
    case (opcode)
      OpLw, OpSw:    nxt = StMemAddr;
      OpRtype:       nxt = StRExec;
      OpBeq:         nxt = StBranch;
`ifdef MULTICYCLE_BNE_EN
      OpBne:         nxt = StBranch;
`endif
      OpJ:           nxt = StJump;
      OpAddi, OpOri: nxt = StIExec;
      default:       nxt = StFetch;
    endcase
    return nxt;
  endfunction

  function automatic logic branch_taken(input logic [5:0] opcode, input logic zero);
`ifdef MULTICYCLE_BNE_EN
    return (opcode == OpBne) ? ~zero : zero;
`else
    return (opcode == OpBne) ? 1'b0 : zero;
`endif
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-output decode for the multicycle MIPS controller.
// Honours MULTICYCLE_BNE_EN through the package helpers.
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_source = PcSrcAlu;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b  = SrcBImmSh2;
        ctrl.alu_op     = AluAdd;
        ctrl.illegal_op = (decode_next(opcode) == StFetch);
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      StRExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = AluFunct;
      end
      StRWb: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = (funct != FunctJr);
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SrcBReg;
        ctrl.alu_op     = AluSub;
        ctrl.pc_source  = PcSrcAluOut;
        ctrl.pc_write   = branch_taken(opcode, zero);
        ctrl.instr_done = 1'b1;
      end
      StJump: begin
        ctrl.pc_source  = PcSrcJump;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StIExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluImm;
      end
      StIWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, next-state logic, output gating.
// Build option: MULTICYCLE_BNE_EN enables bne as a branch instruction.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_out;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode:   state_d = decode_next(opcode);
      StMemAddr:  state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StRExec:    state_d = StRWb;
      StIExec:    state_d = StIWb;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Outputs are forced low during reset so an aborted access never leaves an enable high.
  assign ctrl_out = rst ? '0 : ctrl;

  assign pc_write   = ctrl_out.pc_write;
  assign IorD       = ctrl_out.iord;
  assign MemRead    = ctrl_out.mem_read;
  assign MemWrite   = ctrl_out.mem_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign RegWrite   = ctrl_out.reg_write;
  assign RegDst     = ctrl_out.reg_dst;
  assign MemToReg   = ctrl_out.mem_to_reg;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign ALUSrcB    = ctrl_out.alu_src_b;
  assign ALUOp      = ctrl_out.alu_op;
  assign PCSource   = ctrl_out.pc_source;
  assign instr_done = ctrl_out.instr_done;
  assign illegal_op = ctrl_out.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg;
  logic       ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int total  = 0;
  int passed = 0;

  int exp_path[$];

  logic [16:0] obs;
  assign obs = {pc_write, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  // Sequence of state codes an instruction walks through (waits not included).
  task automatic set_path(input logic [5:0] op);
    exp_path = '{0, 1};
    case (op)
      6'h23:        exp_path = '{0, 1, 2, 3, 4};
      6'h2B:        exp_path = '{0, 1, 2, 5};
      6'h00:        exp_path = '{0, 1, 6, 7};
      6'h04:        exp_path = '{0, 1, 8};
      6'h02:        exp_path = '{0, 1, 9};
      6'h08, 6'h0D: exp_path = '{0, 1, 10, 11};
`ifdef MULTICYCLE_BNE_EN
      6'h05:        exp_path = '{0, 1, 8};
`endif
      default: ;
    endcase
  endtask

  // Output table by state code, in the order of obs.
  function automatic logic [16:0] model_out(input int st, input logic rdy, input logic z,
                                            input logic [5:0] op, input logic [5:0] fn,
                                            input logic legal);
    logic pcw, iord, mr, mw, irw, rw, rd, m2r, sa, done, ill;
    logic [1:0] sb, aop, pcs;
    {pcw, iord, mr, mw, irw, rw, rd, m2r, sa, done, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; ill = !legal; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iord = 1; done = rdy; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = (fn != 6'h08); done = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcw = (op == 6'h05) ? !z : z; done = 1; end
      9:  begin pcs = 2'b10; pcw = 1; done = 1; end
      10: begin sa = 1; sb = 2'b10; aop = 2'b11; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, iord, mr, mw, irw, rw, rd, m2r, sa, sb, aop, pcs, done, ill};
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if ({state, obs} !== 21'd0) $display("FAIL reset_hold cyc=%0d state=%0d outs=%b required 0/0", c, state, obs);
      else passed++;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b1)
      $display("FAIL reset_release state=%0d MemRead=%b IRWrite=%b required 0/1/1", state, MemRead, IRWrite);
    else passed++;
    @(negedge clk);
    total++;
    if (state !== 4'd1) $display("FAIL reset_first_fetch state=%0d required 1", state);
    else passed++;
    // lw from the fetch above: finish it so the next test starts in FETCH
    repeat (4) @(negedge clk);
  endtask

  task automatic test_add();
    logic [3:0] st[4];
    logic [2:0] wr[4];
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1; st[c] = state; wr[c] = {RegWrite, RegDst, instr_done};
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (st[c] !== 4'(exp_path[c])) $display("FAIL add_state cyc=%0d state=%0d required %0d", c, st[c], exp_path[c]);
      else passed++;
    end
    total++;
    if (wr[3] !== 3'b111) $display("FAIL add_writeback got=%b required 111", wr[3]);
    else passed++;
    total++;
    if (wr[2][0] !== 1'b0) $display("FAIL add_early_done got=%b required 0", wr[2][0]);
    else passed++;
  endtask

  task automatic test_lw_wait();
    logic       rdy_seq[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] want[7]    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    opcode = 6'h23; funct = 6'h00; zero = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = rdy_seq[c];
      #1;
      total++;
      if (state !== want[c]) $display("FAIL lw_state cyc=%0d state=%0d required %0d", c, state, want[c]);
      else passed++;
      if (c == 6) begin
        total++;
        if ({RegWrite, MemToReg, instr_done} !== 3'b111)
          $display("FAIL lw_wb got=%b required 111", {RegWrite, MemToReg, instr_done});
        else passed++;
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (state !== 4'd0) $display("FAIL lw_total_len state=%0d required 0", state);
    else passed++;
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z);
    logic legal;
    set_path(op);
    legal = exp_path.size() > 2;
    opcode = op; funct = 6'($urandom_range(0, 63)); zero = z; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (illegal_op !== !legal) $display("FAIL br_illegal op=%h got=%b required %b", op, illegal_op, !legal);
    else passed++;
    @(negedge clk);
    #1;
    if (legal) begin
      total++;
      if ({state, pc_write, PCSource, instr_done} !== {4'd8, model_out(8, 1'b1, z, op, funct, 1'b1)[16], 2'b01, 1'b1})
        $display("FAIL br_exec op=%h z=%b state=%0d pc_write=%b PCSource=%b done=%b required 8/%b/01/1",
                 op, z, state, pc_write, PCSource, instr_done, model_out(8, 1'b1, z, op, funct, 1'b1)[16]);
      else passed++;
      @(negedge clk);
    end else begin
      total++;
      if (state !== 4'd0) $display("FAIL br_return op=%h state=%0d required 0", op, state);
      else passed++;
    end
  endtask

  task automatic test_jr();
    opcode = 6'h00; funct = 6'h08; mem_ready = 1'b1; zero = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({state, RegWrite, RegDst, instr_done} !== {4'd7, 3'b011})
      $display("FAIL jr_wb state=%0d RegWrite=%b RegDst=%b done=%b required 7/0/1/1",
               state, RegWrite, RegDst, instr_done);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    #1;
    total++;
    if (illegal_op !== 1'b0) $display("FAIL ill_fetch got=%b required 0", illegal_op);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({state, illegal_op, instr_done} !== {4'd1, 2'b10})
      $display("FAIL ill_decode state=%0d illegal_op=%b done=%b required 1/1/0", state, illegal_op, instr_done);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({state, illegal_op} !== {4'd0, 1'b0}) $display("FAIL ill_return state=%0d illegal_op=%b required 0/0", state, illegal_op);
    else passed++;
  endtask

  task automatic test_random(input int n_instr);
    logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h00};
    logic [5:0] op;
    logic [16:0] exp;
    int p, guard, s;
    for (int k = 0; k < n_instr; k++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 8)];
      opcode = op;
      funct  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      set_path(op);
      p = 0; guard = 0;
      while (p < exp_path.size() && guard < 40) begin
        zero = 1'($urandom_range(0, 1));
        mem_ready = ($urandom_range(0, 9) < 7);
        #1;
        s = exp_path[p];
        exp = model_out(s, mem_ready, zero, op, funct, exp_path.size() > 2);
        total++;
        if ({state, obs} !== {4'(s), exp})
          $display("FAIL random op=%h step=%0d state=%0d outs=%b required state=%0d outs=%b",
                   op, p, state, obs, s, exp);
        else passed++;
        if (!((s == 0 || s == 3 || s == 5) && !mem_ready)) p++;
        guard++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if ({state, MemWrite} !== {4'd5, 1'b1}) $display("FAIL sw_write state=%0d MemWrite=%b required 5/1", state, MemWrite);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({state, obs} !== 21'd0) $display("FAIL rst_abort state=%0d outs=%b required 0/0", state, obs);
    else passed++;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    total++;
    if ({state, MemRead, IRWrite, MemWrite} !== {4'd0, 3'b110})
      $display("FAIL rst_refetch state=%0d MemRead=%b IRWrite=%b MemWrite=%b required 0/1/1/0",
               state, MemRead, IRWrite, MemWrite);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (state !== 4'd1) $display("FAIL rst_decode state=%0d required 1", state);
    else passed++;
  endtask

  initial begin
    test_reset();
    set_path(6'h00);
    test_add();
    test_lw_wait();
    test_branch(6'h04, 1'b1);
    test_branch(6'h04, 1'b0);
    test_branch(6'h05, 1'b0);
    test_branch(6'h05, 1'b1);
    test_jr();
    test_illegal();
    test_random(80);
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
